fsm_traffic_multi: RTL and testbench



---
 rtl/fsm_traffic_multi.sv | 224 ++++++++++++++++++++++
 tb/tb_fsm_traffic_multi.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_traffic_multi.sv
// -----------------------------------------------------------------------------
// fsm_traffic_multi
//
// Round-robin intersection controller for NUM_PATHS approach paths. Each path
// is served in turn with GREEN -> YELLOW -> ALL_RED, with phase lengths set by
// parameters. Pedestrian walk requests are latched per path and granted at the
// start of that path's green. A night input switches the intersection to a
// flashing-yellow mode at the next all-red exit.
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous, active-high reset
//   walk_req     per-path pedestrian request (pulse or level)
//   night        night-mode request (level)
//   car_lights   per path p: [3p+2:3p] = {red, yellow, green}
//   walk_lights  per path p: [2p+1:2p] = {red, green}
//   active_path  path owning green/yellow, or the next path to be served
//   phase        0 = ALL_RED, 1 = GREEN, 2 = YELLOW, 3 = FLASH
//
// All outputs are registered from the current state registers, so they show
// the state entered at the preceding edge and have no combinational path from
// any input.
// -----------------------------------------------------------------------------
module fsm_traffic_multi #(
  parameter int unsigned NUM_PATHS  = 4,
  parameter int unsigned GREEN_CYC  = 20,
  parameter int unsigned YELLOW_CYC = 4,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned WALK_CYC   = 12,
  parameter int unsigned FLASH_CYC  = 5,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned PathW     = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PATHS-1:0]   walk_req,
  input  logic                   night,
  output logic [3*NUM_PATHS-1:0] car_lights,
  output logic [2*NUM_PATHS-1:0] walk_lights,
  output logic [PathW-1:0]       active_path,
  output logic [1:0]             phase
);

  // State encoding doubles as the phase output code.
  typedef enum logic [1:0] {
    StAllRed = 2'd0,
    StGreen  = 2'd1,
    StYellow = 2'd2,
    StFlash  = 2'd3
  } state_e;

  // Last counter value of each phase: the phase exits on this cycle.
  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WalkLast   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FlashLast  = CNT_W'(FLASH_CYC - 1);
  localparam logic [PathW-1:0] PathLast   = PathW'(NUM_PATHS - 1);

  // Lamp patterns.
  localparam logic [2:0] CarRed    = 3'b100;
  localparam logic [2:0] CarYellow = 3'b010;
  localparam logic [2:0] CarGreen  = 3'b001;
  localparam logic [1:0] WalkRed   = 2'b10;
  localparam logic [1:0] WalkGreen = 2'b01;

  localparam logic [3*NUM_PATHS-1:0] CarAllRed  = {NUM_PATHS{CarRed}};
  localparam logic [2*NUM_PATHS-1:0] WalkAllRed = {NUM_PATHS{WalkRed}};

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PathW-1:0]     path_q, path_d;
  logic [NUM_PATHS-1:0] req_q, req_d;
  // Set when the current green was entered with a pending walk request.
  logic                 grant_q, grant_d;
  // Current flash half-period: 1 = yellow lit, 0 = dark.
  logic                 flash_y_q, flash_y_d;

  // Output registers.
  logic [3*NUM_PATHS-1:0] car_q, car_d;
  logic [2*NUM_PATHS-1:0] walk_q, walk_d;
  logic [PathW-1:0]       active_path_q;
  logic [1:0]             phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAllRed;
      cnt_q     <= '0;
      path_q    <= '0;
      req_q     <= '0;
      grant_q   <= 1'b0;
      flash_y_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      path_q    <= path_d;
      req_q     <= req_d;
      grant_q   <= grant_d;
      flash_y_q <= flash_y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    path_d    = path_q;
    grant_d   = grant_q;
    flash_y_d = flash_y_q;
    // Requests latch in every state, FLASH included.
    req_d     = req_q | walk_req;

    unique case (state_q)
      StAllRed: begin
        if (cnt_q == AllRedLast) begin
          cnt_d = '0;
          if (night) begin
            state_d   = StFlash;
            flash_y_d = 1'b1;
            grant_d   = 1'b0;
          end else begin
            state_d = StGreen;
            grant_d = req_q[path_q];
            // A grant consumes the request; a press in this same cycle is
            // swallowed along with it rather than re-armed.
            if (req_q[path_q]) begin
              req_d[path_q] = 1'b0;
            end
          end
        end
      end

      StGreen: begin
        if (cnt_q == GreenLast) begin
          cnt_d   = '0;
          state_d = StYellow;
        end
      end

      StYellow: begin
        if (cnt_q == YellowLast) begin
          cnt_d   = '0;
          state_d = StAllRed;
          grant_d = 1'b0;
          path_d  = (path_q == PathLast) ? '0 : path_q + 1'b1;
        end
      end

      StFlash: begin
        // night is only looked at on half-period boundaries.
        if (cnt_q == FlashLast) begin
          cnt_d = '0;
          if (night) begin
            flash_y_d = ~flash_y_q;
          end else begin
            state_d = StAllRed;
            path_d  = '0;
          end
        end
      end

      default: begin
        state_d = StAllRed;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (from current state, registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    car_d  = CarAllRed;
    walk_d = WalkAllRed;
    for (int unsigned p = 0; p < NUM_PATHS; p++) begin
      unique case (state_q)
        StGreen: begin
          if (PathW'(p) == path_q) begin
            car_d[3*p +: 3] = CarGreen;
            if (grant_q && (cnt_q <= WalkLast)) begin
              walk_d[2*p +: 2] = WalkGreen;
            end
          end
        end
        StYellow: begin
          if (PathW'(p) == path_q) begin
            car_d[3*p +: 3] = CarYellow;
          end
        end
        StFlash: begin
          car_d[3*p +: 3] = {1'b0, flash_y_q, 1'b0};
        end
        default: begin
          car_d[3*p +: 3] = CarRed;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      car_q         <= CarAllRed;
      walk_q        <= WalkAllRed;
      active_path_q <= '0;
      phase_q       <= 2'd0;
    end else begin
      car_q         <= car_d;
      walk_q        <= walk_d;
      active_path_q <= path_q;
      phase_q       <= state_q;
    end
  end

  assign car_lights  = car_q;
  assign walk_lights = walk_q;
  assign active_path = active_path_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_fsm_traffic_multi.sv
module tb_fsm_traffic_multi;

  localparam int NP = 4;
  localparam int G  = 20;
  localparam int Y  = 4;
  localparam int AR = 2;
  localparam int WK = 12;
  localparam int FL = 5;

  localparam logic [11:0] RED_ALL  = 12'b100_100_100_100;
  localparam logic [11:0] YEL_ALL  = 12'b010_010_010_010;
  localparam logic [11:0] GREEN0   = 12'b100_100_100_001;
  localparam logic [7:0]  WALK_RED = 8'b10_10_10_10;

  logic        clk = 1'b0;
  logic        rst;
  logic        night;
  logic [3:0]  walk_req;
  logic [11:0] car_lights;
  logic [7:0]  walk_lights;
  logic [1:0]  active_path;
  logic [1:0]  phase;

  logic        rst_s;
  logic        night_s;
  logic [2:0]  walk_s;
  logic [8:0]  car_s;
  logic [5:0]  walk_lights_s;
  logic [1:0]  ap_s;
  logic [1:0]  phase_s;

  int errors = 0;
  int checks = 0;
  int cyc    = -1;

  always #5 clk = ~clk;

  fsm_traffic_multi #(
    .NUM_PATHS(4), .GREEN_CYC(20), .YELLOW_CYC(4), .ALLRED_CYC(2),
    .WALK_CYC(12), .FLASH_CYC(5), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .walk_req   (walk_req),
    .night      (night),
    .car_lights (car_lights),
    .walk_lights(walk_lights),
    .active_path(active_path),
    .phase      (phase)
  );

  fsm_traffic_multi #(
    .NUM_PATHS(3), .GREEN_CYC(3), .YELLOW_CYC(1), .ALLRED_CYC(1),
    .WALK_CYC(3), .FLASH_CYC(5), .CNT_W(8)
  ) dut_s (
    .clk        (clk),
    .rst        (rst_s),
    .walk_req   (walk_s),
    .night      (night_s),
    .car_lights (car_s),
    .walk_lights(walk_lights_s),
    .active_path(ap_s),
    .phase      (phase_s)
  );

  // ---------------------------------------------------------------------------
  // Reference model: phase name, cycles remaining in it, path being served,
  // pending requests and remaining walk cycles. exp_* hold the outputs that
  // must appear after the most recent edge.
  // ---------------------------------------------------------------------------
  int         m_ph;        // 0 all-red, 1 green, 2 yellow, 3 flash
  int         m_left;
  int         m_path;
  int         m_walk_left;
  bit         m_y;
  bit [NP-1:0] m_req;
  logic [11:0] exp_car;
  logic [7:0]  exp_walk;
  logic [1:0]  exp_phase;
  logic [1:0]  exp_ap;

  task automatic model_edge(input bit r, input bit [NP-1:0] wr, input bit nt);
    bit [NP-1:0] req_next;
    if (r) begin
      exp_car = RED_ALL; exp_walk = WALK_RED; exp_phase = 2'd0; exp_ap = 2'd0;
      m_ph = 0; m_left = AR; m_path = 0; m_req = '0; m_walk_left = 0; m_y = 1'b0;
      return;
    end
    for (int p = 0; p < NP; p++) begin
      if (m_ph == 3)                     exp_car[3*p +: 3] = {1'b0, m_y, 1'b0};
      else if (m_ph == 1 && p == m_path) exp_car[3*p +: 3] = 3'b001;
      else if (m_ph == 2 && p == m_path) exp_car[3*p +: 3] = 3'b010;
      else                               exp_car[3*p +: 3] = 3'b100;
      exp_walk[2*p +: 2] = (m_ph == 1 && p == m_path && m_walk_left > 0) ? 2'b01 : 2'b10;
    end
    exp_phase = 2'(m_ph);
    exp_ap    = 2'(m_path);

    if (m_ph == 1 && m_walk_left > 0) m_walk_left--;
    m_left--;
    req_next = m_req | wr;
    if (m_left == 0) begin
      case (m_ph)
        0: begin
          if (nt) begin
            m_ph = 3; m_left = FL; m_y = 1'b1;
          end else begin
            m_ph = 1; m_left = G;
            if (m_req[m_path]) begin
              m_walk_left = WK; req_next[m_path] = 1'b0;
            end else begin
              m_walk_left = 0;
            end
          end
        end
        1: begin m_ph = 2; m_left = Y; end
        2: begin m_ph = 0; m_left = AR; m_path = (m_path + 1) % NP; end
        default: begin
          m_left = FL;
          if (nt) m_y = ~m_y;
          else begin m_ph = 0; m_left = AR; m_path = 0; end
        end
      endcase
    end
    m_req = req_next;
  endtask

  task automatic step(input bit r, input bit [NP-1:0] wr, input bit nt);
    rst = r; walk_req = wr; night = nt;
    @(posedge clk);
    model_edge(r, wr, nt);
    if (r) cyc = -1;
    else   cyc++;
    #1;
  endtask

  function automatic bit lamps_ok(input logic [11:0] car, input logic [1:0] ph);
    int nonred;
    logic [2:0] l;
    nonred = 0;
    if (ph == 2'd3) return 1'b1;
    for (int p = 0; p < NP; p++) begin
      l = car[3*p +: 3];
      if (!$onehot(l)) return 1'b0;
      if (l != 3'b100) nonred++;
    end
    return nonred <= 1;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, '0, 1'b0);
      checks += 4;
      if (car_lights !== RED_ALL) begin
        errors++; $display("FAIL reset_car i=%0d got=%b exp=%b", i, car_lights, RED_ALL);
      end
      if (walk_lights !== WALK_RED) begin
        errors++; $display("FAIL reset_walk i=%0d got=%b exp=%b", i, walk_lights, WALK_RED);
      end
      if (phase !== 2'd0) begin
        errors++; $display("FAIL reset_phase i=%0d got=%0d exp=0", i, phase);
      end
      if (active_path !== 2'd0) begin
        errors++; $display("FAIL reset_ap i=%0d got=%0d exp=0", i, active_path);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (car_lights !== ((cyc == 2) ? GREEN0 : RED_ALL)) begin
        errors++;
        $display("FAIL release_car cyc=%0d got=%b exp=%b", cyc, car_lights,
                 (cyc == 2) ? GREEN0 : RED_ALL);
      end
    end
  endtask

  task automatic test_full_round();
    int starts[$];
    int spaths[$];
    int exp_start[5];
    int exp_path[5];
    int wrap_cyc;
    logic [11:0] prev_car;
    logic [1:0]  prev_ap;
    exp_start = '{2, 28, 54, 80, 106};
    exp_path  = '{0, 1, 2, 3, 0};
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    prev_car = RED_ALL; prev_ap = 2'd0; wrap_cyc = -1;
    while (cyc < 130) begin
      step(1'b0, '0, 1'b0);
      checks += 5;
      if (car_lights !== exp_car) begin
        errors++; $display("FAIL round_car cyc=%0d got=%b exp=%b", cyc, car_lights, exp_car);
      end
      if (walk_lights !== exp_walk) begin
        errors++; $display("FAIL round_walk cyc=%0d got=%b exp=%b", cyc, walk_lights, exp_walk);
      end
      if (phase !== exp_phase) begin
        errors++; $display("FAIL round_phase cyc=%0d got=%0d exp=%0d", cyc, phase, exp_phase);
      end
      if (active_path !== exp_ap) begin
        errors++; $display("FAIL round_ap cyc=%0d got=%0d exp=%0d", cyc, active_path, exp_ap);
      end
      if (!lamps_ok(car_lights, phase)) begin
        errors++; $display("FAIL round_onehot cyc=%0d got=%b exp=one_lamp_max_one_path", cyc,
                           car_lights);
      end
      for (int p = 0; p < NP; p++) begin
        if (car_lights[3*p] === 1'b1 && prev_car[3*p] !== 1'b1) begin
          starts.push_back(cyc); spaths.push_back(p);
        end
      end
      if (prev_ap == 2'd3 && active_path == 2'd0 && wrap_cyc < 0) wrap_cyc = cyc;
      prev_car = car_lights; prev_ap = active_path;
    end
    checks++;
    if (starts.size() != 5) begin
      errors++; $display("FAIL green_count got=%0d exp=5", starts.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks += 2;
        if (starts[i] != exp_start[i]) begin
          errors++; $display("FAIL green_start i=%0d got=%0d exp=%0d", i, starts[i], exp_start[i]);
        end
        if (spaths[i] != exp_path[i]) begin
          errors++; $display("FAIL green_path i=%0d got=%0d exp=%0d", i, spaths[i], exp_path[i]);
        end
      end
    end
    checks++;
    if (wrap_cyc != 104) begin
      errors++; $display("FAIL ap_wrap got=%0d exp=104", wrap_cyc);
    end
  endtask

  task automatic test_walk();
    bit [NP-1:0] wr;
    logic [1:0] exp0, exp2;
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    while (cyc < 170) begin
      wr = '0;
      if (cyc + 1 == 5)  wr[0] = 1'b1;
      if (cyc + 1 == 10) wr[2] = 1'b1;
      step(1'b0, wr, 1'b0);
      exp2 = (cyc >= 54 && cyc <= 65) ? 2'b01 : 2'b10;
      exp0 = (cyc >= 106 && cyc <= 117) ? 2'b01 : 2'b10;
      checks += 3;
      if (walk_lights[5:4] !== exp2) begin
        errors++; $display("FAIL walk2 cyc=%0d got=%b exp=%b", cyc, walk_lights[5:4], exp2);
      end
      if (walk_lights[1:0] !== exp0) begin
        errors++; $display("FAIL walk0 cyc=%0d got=%b exp=%b", cyc, walk_lights[1:0], exp0);
      end
      if (walk_lights !== exp_walk) begin
        errors++; $display("FAIL walk_all cyc=%0d got=%b exp=%b", cyc, walk_lights, exp_walk);
      end
    end
  endtask

  task automatic test_night();
    bit nt;
    int t_flash;
    int t_exit;
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    t_flash = -1; t_exit = -1;
    while (cyc < 90) begin
      nt = (cyc + 1 >= 15) && (cyc + 1 < 40);
      step(1'b0, '0, nt);
      checks += 3;
      if (car_lights !== exp_car) begin
        errors++; $display("FAIL night_car cyc=%0d got=%b exp=%b", cyc, car_lights, exp_car);
      end
      if (walk_lights !== exp_walk) begin
        errors++; $display("FAIL night_walk cyc=%0d got=%b exp=%b", cyc, walk_lights, exp_walk);
      end
      if (phase !== exp_phase) begin
        errors++; $display("FAIL night_phase cyc=%0d got=%0d exp=%0d", cyc, phase, exp_phase);
      end
      if (phase === 2'd3 && t_flash < 0) t_flash = cyc;
      if (t_flash >= 0 && t_exit < 0 && phase === 2'd0) t_exit = cyc;
      if (cyc >= 28 && cyc <= 32) begin
        checks++;
        if (car_lights !== YEL_ALL) begin
          errors++; $display("FAIL flash_on cyc=%0d got=%b exp=%b", cyc, car_lights, YEL_ALL);
        end
      end
      if (cyc >= 33 && cyc <= 37) begin
        checks++;
        if (car_lights !== 12'd0) begin
          errors++; $display("FAIL flash_off cyc=%0d got=%b exp=0", cyc, car_lights);
        end
      end
      if (t_exit >= 0 && cyc == t_exit + AR) begin
        checks += 2;
        if (car_lights !== GREEN0) begin
          errors++; $display("FAIL night_green0 cyc=%0d got=%b exp=%b", cyc, car_lights, GREEN0);
        end
        if (active_path !== 2'd0) begin
          errors++; $display("FAIL night_ap cyc=%0d got=%0d exp=0", cyc, active_path);
        end
      end
    end
    checks += 2;
    if (t_flash != 28) begin
      errors++; $display("FAIL flash_start got=%0d exp=28", t_flash);
    end
    if (t_exit <= 40 || t_exit > 40 + FL + 1) begin
      errors++; $display("FAIL night_exit got=%0d exp=41..%0d", t_exit, 40 + FL + 1);
    end
  endtask

  task automatic test_mid_reset();
    bit [NP-1:0] wr;
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    while (cyc < 59) begin
      wr = (cyc + 1 == 5) ? 4'b1000 : 4'b0000;
      step(1'b0, wr, 1'b0);
      checks++;
      if (car_lights !== exp_car) begin
        errors++; $display("FAIL pre_rst_car cyc=%0d got=%b exp=%b", cyc, car_lights, exp_car);
      end
    end
    checks++;
    if (active_path !== 2'd2) begin
      errors++; $display("FAIL pre_rst_ap got=%0d exp=2", active_path);
    end
    step(1'b1, '0, 1'b0);
    checks += 4;
    if (car_lights !== RED_ALL) begin
      errors++; $display("FAIL mid_rst_car got=%b exp=%b", car_lights, RED_ALL);
    end
    if (walk_lights !== WALK_RED) begin
      errors++; $display("FAIL mid_rst_walk got=%b exp=%b", walk_lights, WALK_RED);
    end
    if (phase !== 2'd0) begin
      errors++; $display("FAIL mid_rst_phase got=%0d exp=0", phase);
    end
    if (active_path !== 2'd0) begin
      errors++; $display("FAIL mid_rst_ap got=%0d exp=0", active_path);
    end
    while (cyc < 110) begin
      step(1'b0, '0, 1'b0);
      checks += 2;
      if (walk_lights[7:6] !== 2'b10) begin
        errors++; $display("FAIL lost_req3 cyc=%0d got=%b exp=10", cyc, walk_lights[7:6]);
      end
      if (car_lights !== exp_car) begin
        errors++; $display("FAIL post_rst_car cyc=%0d got=%b exp=%b", cyc, car_lights, exp_car);
      end
    end
  endtask

  task automatic test_random();
    bit nt;
    bit r;
    bit [NP-1:0] wr;
    nt = 1'b0;
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      wr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 199) == 0) nt = ~nt;
      r = ($urandom_range(0, 599) == 0);
      step(r, wr, nt);
      checks += 5;
      if (car_lights !== exp_car) begin
        errors++; $display("FAIL rnd_car i=%0d got=%b exp=%b", i, car_lights, exp_car);
      end
      if (walk_lights !== exp_walk) begin
        errors++; $display("FAIL rnd_walk i=%0d got=%b exp=%b", i, walk_lights, exp_walk);
      end
      if (phase !== exp_phase) begin
        errors++; $display("FAIL rnd_phase i=%0d got=%0d exp=%0d", i, phase, exp_phase);
      end
      if (active_path !== exp_ap) begin
        errors++; $display("FAIL rnd_ap i=%0d got=%0d exp=%0d", i, active_path, exp_ap);
      end
      if (!lamps_ok(car_lights, phase)) begin
        errors++; $display("FAIL rnd_onehot i=%0d got=%b exp=one_lamp_max_one_path", i,
                           car_lights);
      end
    end
  endtask

  // Small configuration: 5-cycle period per path (1 all-red, 3 green, 1 yellow).
  task automatic test_sweep();
    int pos;
    int sp;
    logic [8:0] ec;
    logic [5:0] ew;
    logic [1:0] eph;
    rst = 1'b1;
    rst_s = 1'b1; walk_s = '0; night_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      rst_s = 1'b0; walk_s = 3'b111;
      @(posedge clk);
      #1;
      pos = k % 5;
      sp  = (k / 5) % 3;
      eph = (pos == 0) ? 2'd0 : (pos == 4) ? 2'd2 : 2'd1;
      for (int p = 0; p < 3; p++) begin
        if (pos == 0 || p != sp) ec[3*p +: 3] = 3'b100;
        else                     ec[3*p +: 3] = (pos == 4) ? 3'b010 : 3'b001;
        // First visit to path 0 finds no request yet: it is latched on that edge.
        ew[2*p +: 2] = (p == sp && pos >= 1 && pos <= 3 && k >= 5) ? 2'b01 : 2'b10;
      end
      checks += 4;
      if (car_s !== ec) begin
        errors++; $display("FAIL sweep_car k=%0d got=%b exp=%b", k, car_s, ec);
      end
      if (walk_lights_s !== ew) begin
        errors++; $display("FAIL sweep_walk k=%0d got=%b exp=%b", k, walk_lights_s, ew);
      end
      if (phase_s !== eph) begin
        errors++; $display("FAIL sweep_phase k=%0d got=%0d exp=%0d", k, phase_s, eph);
      end
      if (ap_s !== 2'(sp)) begin
        errors++; $display("FAIL sweep_ap k=%0d got=%0d exp=%0d", k, ap_s, sp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; walk_req = '0; night = 1'b0;
    rst_s = 1'b1; walk_s = '0; night_s = 1'b0;
    test_reset();
    test_full_round();
    test_walk();
    test_night();
    test_mid_reset();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
